// File: rtl/bsram_host_arbiter.sv
// bsram_host_arbiter
//
// Shares the cartridge BSRAM port between the active mapper and a host-side
// save-file loader. The mapper always wins and is never stalled. Host byte
// accesses only start after the mapper has left chip-enable high for a full
// idle window. If the mapper reclaims the port mid-access, the host access
// is dropped and retried after the next full idle window. A dirty flag tracks
// mapper writes so the host knows when the save file must be written back.
//
// Parameters
//   AW           BSRAM address width
//   IDLE_CYCLES  mapper-idle cycles required before a host access (1..15)
//   ACC_CYCLES   cycles a host access holds the BSRAM port (1..15)
//
// Ports
//   mclk, rst_n                 master clock, async active-low reset
//   map_bsram_*                 mapper side of the BSRAM bus (ce/oe/we active low)
//   host_req/we/addr/d          host request (level) and its sampled operands
//   host_ack, host_q            one-cycle completion pulse and read data
//   dirty, dirty_clr            mapper-wrote-BSRAM flag and its clear
//   busy                        host access currently holds the port
//   abort_cnt                   saturating count of aborted host accesses
//   bsram_*                     muxed BSRAM bus; bsram_q is read data

module bsram_host_arbiter #(
   parameter int AW          = 20,
   parameter int IDLE_CYCLES = 4,
   parameter int ACC_CYCLES  = 3
) (
   input  logic          mclk,
   input  logic          rst_n,

   input  logic [AW-1:0] map_bsram_addr,
   input  logic [7:0]    map_bsram_d,
   input  logic          map_bsram_ce_n,
   input  logic          map_bsram_oe_n,
   input  logic          map_bsram_we_n,

   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [7:0]    host_d,
   output logic          host_ack,
   output logic [7:0]    host_q,

   output logic          dirty,
   input  logic          dirty_clr,
   output logic          busy,
   output logic [7:0]    abort_cnt,

   output logic [AW-1:0] bsram_addr,
   output logic [7:0]    bsram_d,
   input  logic [7:0]    bsram_q,
   output logic          bsram_ce_n,
   output logic          bsram_oe_n,
   output logic          bsram_we_n
);

   localparam logic [3:0] IDLE_MAX = 4'(IDLE_CYCLES);
   localparam logic [3:0] ACC_LAST = 4'(ACC_CYCLES - 1);

   typedef enum logic {
      ST_IDLE,
      ST_ACCESS
   } state_t;

   state_t          state;
   logic [3:0]      idle_cnt;
   logic [3:0]      acc_cnt;
   logic            lat_we;
   logic [AW-1:0]   lat_addr;
   logic [7:0]      lat_d;

   logic            window_open;
   logic            start;
   logic            host_drive;

   assign window_open = (idle_cnt == IDLE_MAX);

   // The ack cycle is excluded so a level request still high from the previous
   // transfer cannot be granted twice; the earliest next grant is one cycle later.
   assign start = (state == ST_IDLE) && host_req && !host_ack
                  && window_open && map_bsram_ce_n;

   // The host only owns the bus while the mapper keeps chip-enable high;
   // a falling mapper ce_n hands the port back in the very same cycle.
   assign host_drive = (state == ST_ACCESS) && map_bsram_ce_n;

   assign busy = (state == ST_ACCESS);

   // Count consecutive mapper-idle cycles, saturating at the window length.
   // Any mapper access restarts the window, which also covers the abort case.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         idle_cnt <= 4'd0;
      end else if (!map_bsram_ce_n) begin
         idle_cnt <= 4'd0;
      end else if (idle_cnt != IDLE_MAX) begin
         idle_cnt <= idle_cnt + 4'd1;
      end
   end

   // Host access sequencer. Operands are latched at grant so the host may
   // change or drop its request while the access is in flight. An abort
   // leaves host_req untouched, so the same request is simply granted again
   // after the next idle window and a write is re-issued in full.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         acc_cnt   <= 4'd0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_d     <= 8'h00;
         host_ack  <= 1'b0;
         host_q    <= 8'h00;
         abort_cnt <= 8'h00;
      end else begin
         host_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_ACCESS;
                  acc_cnt  <= 4'd0;
                  lat_we   <= host_we;
                  lat_addr <= host_addr;
                  lat_d    <= host_d;
               end
            end
            ST_ACCESS: begin
               acc_cnt <= acc_cnt + 4'd1;
               if (!map_bsram_ce_n) begin
                  state <= ST_IDLE;
                  if (abort_cnt != 8'hFF) begin
                     abort_cnt <= abort_cnt + 8'h01;
                  end
               end else if (acc_cnt == ACC_LAST) begin
                  state    <= ST_IDLE;
                  host_ack <= 1'b1;
                  if (!lat_we) begin
                     host_q <= bsram_q;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Only mapper writes mark the save data dirty; a coincident clear loses
   // so a write landing during the host's clear is never forgotten.
   always_ff @(posedge mclk or negedge rst_n) begin
      if (!rst_n) begin
         dirty <= 1'b0;
      end else if (!map_bsram_ce_n && !map_bsram_we_n) begin
         dirty <= 1'b1;
      end else if (dirty_clr) begin
         dirty <= 1'b0;
      end
   end

   // Port mux: the mapper passes straight through unless a host access
   // currently owns the bus.
   always_comb begin
      bsram_addr = map_bsram_addr;
      bsram_d    = map_bsram_d;
      bsram_ce_n = map_bsram_ce_n;
      bsram_oe_n = map_bsram_oe_n;
      bsram_we_n = map_bsram_we_n;
      if (host_drive) begin
         bsram_addr = lat_addr;
         bsram_d    = lat_d;
         bsram_ce_n = 1'b0;
         bsram_oe_n = lat_we;
         bsram_we_n = ~lat_we;
      end
   end

endmodule

// File: tb/tb_bsram_host_arbiter.sv
// tb_bsram_host_arbiter
//
// Directed bench for bsram_host_arbiter with a small BSRAM model hanging off
// the muxed port. Expected values are hand-computed from the block's
// behaviour (IDLE_CYCLES=4, ACC_CYCLES=3).

module tb_bsram_host_arbiter;

   localparam int AW = 20;

   logic          mclk;
   logic          rst_n;
   logic [AW-1:0] map_bsram_addr;
   logic [7:0]    map_bsram_d;
   logic          map_bsram_ce_n;
   logic          map_bsram_oe_n;
   logic          map_bsram_we_n;
   logic          host_req;
   logic          host_we;
   logic [AW-1:0] host_addr;
   logic [7:0]    host_d;
   logic          host_ack;
   logic [7:0]    host_q;
   logic          dirty;
   logic          dirty_clr;
   logic          busy;
   logic [7:0]    abort_cnt;
   logic [AW-1:0] bsram_addr;
   logic [7:0]    bsram_d;
   logic [7:0]    bsram_q;
   logic          bsram_ce_n;
   logic          bsram_oe_n;
   logic          bsram_we_n;

   int vectors;
   int miscompares;

   bsram_host_arbiter #(
      .AW(AW),
      .IDLE_CYCLES(4),
      .ACC_CYCLES(3)
   ) dut (
      .mclk(mclk),
      .rst_n(rst_n),
      .map_bsram_addr(map_bsram_addr),
      .map_bsram_d(map_bsram_d),
      .map_bsram_ce_n(map_bsram_ce_n),
      .map_bsram_oe_n(map_bsram_oe_n),
      .map_bsram_we_n(map_bsram_we_n),
      .host_req(host_req),
      .host_we(host_we),
      .host_addr(host_addr),
      .host_d(host_d),
      .host_ack(host_ack),
      .host_q(host_q),
      .dirty(dirty),
      .dirty_clr(dirty_clr),
      .busy(busy),
      .abort_cnt(abort_cnt),
      .bsram_addr(bsram_addr),
      .bsram_d(bsram_d),
      .bsram_q(bsram_q),
      .bsram_ce_n(bsram_ce_n),
      .bsram_oe_n(bsram_oe_n),
      .bsram_we_n(bsram_we_n)
   );

   // Free-running master clock.
   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   // BSRAM model: asynchronous read, write on clock edge. The preload port
   // lets the bench seed contents without a second driver on the array.
   logic [7:0]  mem [0:4095];
   logic        pre_we;
   logic [11:0] pre_addr;
   logic [7:0]  pre_d;

   always @(posedge mclk) begin
      if (pre_we) begin
         mem[pre_addr] <= pre_d;
      end else if (!bsram_ce_n && !bsram_we_n) begin
         mem[bsram_addr[11:0]] <= bsram_d;
      end
   end

   assign bsram_q = mem[bsram_addr[11:0]];

   // Advance one clock and land 1 time unit after the edge.
   task automatic stepCycle();
      @(posedge mclk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      if (observed !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive the mapper side of the bus for the current cycle.
   task automatic applyStimulus(input logic ce_n, input logic oe_n, input logic we_n,
                                input logic [AW-1:0] addr, input logic [7:0] d);
      map_bsram_ce_n = ce_n;
      map_bsram_oe_n = oe_n;
      map_bsram_we_n = we_n;
      map_bsram_addr = addr;
      map_bsram_d    = d;
   endtask

   task automatic mapperIdle();
      applyStimulus(1'b1, 1'b1, 1'b1, 20'h55555, 8'h33);
   endtask

   task automatic preload(input logic [11:0] addr, input logic [7:0] d);
      pre_we   = 1'b1;
      pre_addr = addr;
      pre_d    = d;
      stepCycle();
      pre_we   = 1'b0;
   endtask

   task automatic hostRequest(input logic we, input logic [AW-1:0] addr, input logic [7:0] d);
      host_req  = 1'b1;
      host_we   = we;
      host_addr = addr;
      host_d    = d;
   endtask

   // Step until busy rises (bounded); n is the number of edges taken.
   task automatic waitGrant(input string tag, output int n);
      n = 0;
      while (!busy && n < 40) begin
         stepCycle();
         n++;
      end
      checkOutput({tag, "_granted"}, 32'(busy), 32'd1);
   endtask

   // From the first ACCESS cycle, step until host_ack (bounded); counts
   // edges taken and cycles with the BSRAM write strobe low.
   task automatic waitAck(input string tag, output int lat, output int we_low);
      lat    = 0;
      we_low = 0;
      while (!host_ack && lat < 40) begin
         if (!bsram_we_n) we_low++;
         stepCycle();
         lat++;
      end
      checkOutput({tag, "_acked"}, 32'(host_ack), 32'd1);
   endtask

   initial begin
      int n;
      int lat;
      int we_low;
      int mirror_err;
      int ack_seen;
      int busy_seen;

      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      host_req    = 1'b0;
      host_we     = 1'b0;
      host_addr   = '0;
      host_d      = 8'h00;
      dirty_clr   = 1'b0;
      pre_we      = 1'b0;
      pre_addr    = 12'h000;
      pre_d       = 8'h00;
      mapperIdle();

      preload(12'h123, 8'h5A);
      preload(12'h010, 8'h00);
      preload(12'h200, 8'h77);

      // Reset state and mapper passthrough.
      checkOutput("rst_host_ack", 32'(host_ack), 32'd0);
      checkOutput("rst_host_q", 32'(host_q), 32'h00);
      checkOutput("rst_dirty", 32'(dirty), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_abort_cnt", 32'(abort_cnt), 32'd0);
      checkOutput("rst_pass_addr", 32'(bsram_addr), 32'h55555);
      checkOutput("rst_pass_ce_n", 32'(bsram_ce_n), 32'd1);

      // Test 1: host read of 0x00123 after a full idle window.
      stepCycle();
      rst_n = 1'b1;
      hostRequest(1'b0, 20'h00123, 8'h00);
      waitGrant("t1", n);
      checkOutput("t1_grant_wait", 32'(n), 32'd5);
      checkOutput("t1_bus_addr", 32'(bsram_addr), 32'h00123);
      checkOutput("t1_bus_ce_n", 32'(bsram_ce_n), 32'd0);
      checkOutput("t1_bus_oe_n", 32'(bsram_oe_n), 32'd0);
      checkOutput("t1_bus_we_n", 32'(bsram_we_n), 32'd1);
      waitAck("t1", lat, we_low);
      checkOutput("t1_ack_latency", 32'(lat), 32'd3);
      checkOutput("t1_host_q", 32'(host_q), 32'h5A);
      host_req = 1'b0;
      stepCycle();
      checkOutput("t1_ack_one_cycle", 32'(host_ack), 32'd0);
      checkOutput("t1_busy_after", 32'(busy), 32'd0);

      // Test 2: host write 0xA5 to 0x00010, then back-to-back readback.
      hostRequest(1'b1, 20'h00010, 8'hA5);
      waitGrant("t2", n);
      checkOutput("t2_grant_wait", 32'(n), 32'd1);
      checkOutput("t2_bus_addr", 32'(bsram_addr), 32'h00010);
      checkOutput("t2_bus_d", 32'(bsram_d), 32'hA5);
      waitAck("t2", lat, we_low);
      checkOutput("t2_ack_latency", 32'(lat), 32'd3);
      checkOutput("t2_we_low_cycles", 32'(we_low), 32'd3);
      checkOutput("t2_mem_written", 32'(mem[12'h010]), 32'hA5);
      checkOutput("t2_dirty_host_write", 32'(dirty), 32'd0);
      hostRequest(1'b0, 20'h00010, 8'h00);
      stepCycle();
      checkOutput("t2_no_grant_in_ack", 32'(busy), 32'd0);
      stepCycle();
      checkOutput("t2_grant_after_ack", 32'(busy), 32'd1);
      waitAck("t2rb", lat, we_low);
      checkOutput("t2_readback", 32'(host_q), 32'hA5);
      host_req = 1'b0;
      stepCycle();

      // Test 3: mapper ce_n low every third cycle starves the host.
      hostRequest(1'b0, 20'h00200, 8'h00);
      mirror_err = 0;
      ack_seen   = 0;
      busy_seen  = 0;
      for (int i = 0; i < 30; i++) begin
         if (i % 3 == 0) applyStimulus(1'b0, 1'b0, 1'b1, 20'h00456, 8'h66);
         else            mapperIdle();
         #1;
         if ({bsram_addr, bsram_d, bsram_ce_n, bsram_oe_n, bsram_we_n} !==
             {map_bsram_addr, map_bsram_d, map_bsram_ce_n, map_bsram_oe_n, map_bsram_we_n})
            mirror_err++;
         if (host_ack) ack_seen++;
         if (busy) busy_seen++;
         stepCycle();
      end
      checkOutput("t3_mirror_errors", 32'(mirror_err), 32'd0);
      checkOutput("t3_acks", 32'(ack_seen), 32'd0);
      checkOutput("t3_busy_cycles", 32'(busy_seen), 32'd0);

      // Test 4: mapper reclaims the port in the 2nd ACCESS cycle, then retry.
      mapperIdle();
      waitGrant("t4", n);
      checkOutput("t4_grant_wait", 32'(n), 32'd3);
      stepCycle();
      applyStimulus(1'b0, 1'b0, 1'b1, 20'h00456, 8'h66);
      #1;
      checkOutput("t4_switch_ce_n", 32'(bsram_ce_n), 32'd0);
      checkOutput("t4_switch_addr", 32'(bsram_addr), 32'h00456);
      checkOutput("t4_switch_we_n", 32'(bsram_we_n), 32'd1);
      stepCycle();
      checkOutput("t4_abort_busy", 32'(busy), 32'd0);
      checkOutput("t4_abort_cnt", 32'(abort_cnt), 32'd1);
      checkOutput("t4_abort_no_ack", 32'(host_ack), 32'd0);
      mapperIdle();
      waitGrant("t4rt", n);
      checkOutput("t4_retry_wait", 32'(n), 32'd5);
      waitAck("t4rt", lat, we_low);
      checkOutput("t4_retry_latency", 32'(lat), 32'd3);
      checkOutput("t4_retry_data", 32'(host_q), 32'h77);
      host_req = 1'b0;
      stepCycle();

      // Test 5: dirty flag set, set-beats-clear, lone clear.
      applyStimulus(1'b0, 1'b1, 1'b0, 20'h00300, 8'h11);
      stepCycle();
      mapperIdle();
      checkOutput("t5_dirty_set", 32'(dirty), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 20'h00301, 8'h22);
      dirty_clr = 1'b1;
      stepCycle();
      mapperIdle();
      dirty_clr = 1'b0;
      checkOutput("t5_set_wins", 32'(dirty), 32'd1);
      dirty_clr = 1'b1;
      stepCycle();
      dirty_clr = 1'b0;
      checkOutput("t5_cleared", 32'(dirty), 32'd0);

      // Test 6: reset asserted mid-ACCESS.
      hostRequest(1'b0, 20'h00123, 8'h00);
      waitGrant("t6", n);
      stepCycle();
      rst_n = 1'b0;
      #1;
      checkOutput("t6_rst_busy", 32'(busy), 32'd0);
      checkOutput("t6_rst_host_q", 32'(host_q), 32'h00);
      checkOutput("t6_rst_abort_cnt", 32'(abort_cnt), 32'd0);
      checkOutput("t6_rst_pass_ce_n", 32'(bsram_ce_n), 32'd1);
      checkOutput("t6_rst_pass_addr", 32'(bsram_addr), 32'h55555);
      stepCycle();
      stepCycle();
      rst_n = 1'b1;
      ack_seen = 0;
      n = 0;
      while (!busy && n < 40) begin
         if (host_ack) ack_seen++;
         stepCycle();
         n++;
      end
      checkOutput("t6_no_early_ack", 32'(ack_seen), 32'd0);
      checkOutput("t6_regrant_wait", 32'(n), 32'd5);
      waitAck("t6", lat, we_low);
      checkOutput("t6_host_q", 32'(host_q), 32'h5A);
      host_req = 1'b0;
      stepCycle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/bsram_host_arbiter.md
Name: bsram_host_arbiter

Overview:
Shares the single cartridge BSRAM port between the active mapper (selected by the top-level mapper mux) and a host-side save-file loader/unloader. The mapper always has absolute priority and is never stalled. Host byte accesses are fitted into idle gaps of the mapper's chip-enable and are aborted and retried if the mapper reclaims the port. The block also keeps a dirty flag so the host knows when to write the save file back.

Parameters:
AW, 20, BSRAM address width
IDLE_CYCLES, 4, consecutive mapper-idle cycles required before a host access may start (1..15)
ACC_CYCLES, 3, cycles a host access occupies the BSRAM port (1..15)

Ports:
mclk  in  1  system master clock
rst_n  in  1  asynchronous active-low reset
map_bsram_addr  in  AW  mapper BSRAM address
map_bsram_d  in  8  mapper write data
map_bsram_ce_n  in  1  mapper chip enable (active low)
map_bsram_oe_n  in  1  mapper output enable
map_bsram_we_n  in  1  mapper write enable
host_req  in  1  host request; level, held until host_ack
host_we  in  1  1 = write, 0 = read; sampled at grant
host_addr  in  AW  host address; sampled at grant
host_d  in  8  host write data; sampled at grant
host_ack  out  1  one-cycle completion pulse
host_q  out  8  read data, valid from the host_ack cycle until the next ack
dirty  out  1  mapper has written BSRAM since the last dirty_clr
dirty_clr  in  1  clears dirty
busy  out  1  host access in progress
abort_cnt  out  8  saturating count of aborted host accesses
bsram_addr  out  AW  to BSRAM
bsram_d  out  8  to BSRAM
bsram_q  in  8  from BSRAM; the mapper also reads it directly
bsram_ce_n, bsram_oe_n, bsram_we_n  out  1 each  to BSRAM

Behaviour:
- Clock and reset: single clock mclk. Reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, idle_cnt 0, host_ack 0, host_q 0x00, dirty 0, busy 0, abort_cnt 0. The BSRAM outputs pass the mapper through combinationally.
- idle_cnt: when map_bsram_ce_n=1, increments and saturates at IDLE_CYCLES; when map_bsram_ce_n=0, resets to 0.
- IDLE state:
  - Start condition: host_req=1, host_ack=0, idle_cnt==IDLE_CYCLES, and map_bsram_ce_n=1 in the same cycle.
  - On start: go to ACCESS, latch host_we/host_addr/host_d, acc_cnt=0.
- ACCESS state, port drive:
  - busy=1.
  - While map_bsram_ce_n=1: bsram_addr=latched addr, bsram_d=latched data, bsram_ce_n=0, bsram_oe_n=latched we, bsram_we_n=~latched we.
- ACCESS state, progress: acc_cnt increments each cycle.
- ACCESS state, completion: when acc_cnt==ACC_CYCLES-1 with no abort:
  - host_q<=bsram_q on reads; host_q unchanged on writes.
  - host_ack<=1 for exactly the next cycle; go to IDLE.
  - Latency from grant to ack = ACC_CYCLES cycles.
- Abort:
  - Trigger: map_bsram_ce_n=0 in any ACCESS cycle.
  - The mux selects the mapper in that same cycle (combinational, no hold-off).
  - Go to IDLE, no ack, abort_cnt+1 (saturates at 255), idle_cnt restarts.
  - The request stays pending and is retried after the next full idle window; a write is re-issued whole.
- host_req deasserted mid-access: the access still completes and acks. host_req deasserted in IDLE: nothing pending.
- Back-to-back requests: no grant is allowed in the ack cycle. The earliest next grant is the cycle after the ack, with idle_cnt still saturated if the mapper stayed idle.
- Mux default: in every non-ACCESS cycle, or whenever map_bsram_ce_n=0, all bsram_* outputs equal the map_bsram_* inputs.
- dirty:
  - Set on any cycle with map_bsram_ce_n=0 and map_bsram_we_n=0.
  - Cleared by dirty_clr=1.
  - Simultaneous set and clear: set wins.
  - Host writes never set dirty.
- Reset mid-access: immediate return to IDLE, no ack, pending request discarded.

Test Plan:
1. Mapper idle; host read addr 0x00123, memory holds 0x5A → grant when idle_cnt=4, ack 3 cycles later, host_q=0x5A, exactly 1 ack cycle.
2. Host write 0xA5 to 0x00010, mapper idle → bsram_we_n low for exactly 3 cycles at addr 0x00010; dirty stays 0; readback returns 0xA5.
3. Mapper ce_n pulses low every 3 cycles with IDLE_CYCLES=4 → no grant ever; host_ack never asserts; bsram always mirrors the mapper.
4. Mapper ce_n falls in the 2nd ACCESS cycle → same-cycle switch to the mapper, abort_cnt=1, no ack; retry after 4 idle cycles succeeds with correct data.
5. Mapper write with ce_n=0, we_n=0 → dirty=1 next cycle; dirty_clr coincident with a second mapper write → dirty stays 1; lone dirty_clr → dirty=0.
6. rst_n asserted mid-ACCESS → outputs immediately at reset values, bsram passes the mapper through, no ack after release until a new idle window.
